// File: rtl/ascon_spi_pkg.sv
// Shared types and constants for the SPI frame controller feeding the Ascon core.
package ascon_spi_pkg;

  localparam int unsigned WORD_W = 32;

  // Header field positions
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned LEN_MSB = 15;
  localparam int unsigned LEN_LSB = 0;

  typedef enum logic [3:0] {
    OP_KEY   = 4'd1,
    OP_NONCE = 4'd2,
    OP_DATA  = 4'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY,
    ST_NONCE,
    ST_DATA
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_HDR  = 2'd1,
    ERR_OVF  = 2'd2,
    ERR_TMO  = 2'd3
  } err_t;

endpackage

// File: rtl/ascon_spi_ctrl_buf.sv
// One-entry valid/ready buffer for payload words; flags words that arrive while it is full.
module spi_word_buf
  import ascon_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  input  logic              force_last,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              ovf
);

  logic can_load;
  logic accept;

  assign accept   = out_valid && out_ready;
  assign can_load = !out_valid || out_ready;
  assign ovf      = in_valid && !can_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_valid && can_load) begin
      // Reload on the same cycle as a handshake, so back-to-back words see no bubble
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (force_last && out_valid) begin
      out_last  <= 1'b1;
    end
  end

endmodule

// File: rtl/ascon_spi_ctrl.sv
// Frame controller: decodes SPI header words, assembles key/nonce, streams payload to the core.
module ascon_spi_ctrl
  import ascon_spi_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  output logic [127:0] key,
  output logic         key_valid,
  output logic [127:0] nonce,
  output logic         nonce_valid,
  output logic [31:0]  data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         data_last,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code,
  input  logic         err_clr
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  state_t       state, nxt_state;
  err_t         code_q, new_code;
  logic [3:0]   hop;
  logic [15:0]  hlen;
  logic [127:0] shadow;
  logic [1:0]   wcnt;
  logic [15:0]  rem;
  logic [31:0]  tcnt;
  logic         tmo;
  logic         hdr_err;
  logic         ovf;
  logic         new_err;
  logic         buf_in_valid;

  assign hop  = word_in[OP_MSB:OP_LSB];
  assign hlen = word_in[LEN_MSB:LEN_LSB];
  assign tmo  = (state != ST_IDLE) && !word_valid && (tcnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    hdr_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word_valid) begin
          case (hop)
            OP_KEY:   nxt_state = ST_KEY;
            OP_NONCE: nxt_state = ST_NONCE;
            OP_DATA: begin
              if (hlen != 16'd0 && hlen <= MAX_LEN_W) nxt_state = ST_DATA;
              else                                    hdr_err   = 1'b1;
            end
            default:  hdr_err = 1'b1;
          endcase
        end
      end
      ST_KEY, ST_NONCE: begin
        if (tmo)                              nxt_state = ST_IDLE;
        else if (word_valid && wcnt == 2'd3)  nxt_state = ST_IDLE;
      end
      ST_DATA: begin
        if (tmo)                              nxt_state = ST_IDLE;
        else if (word_valid && rem == 16'd1)  nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Shadow, word counters and inter-word timer; the shadow is wiped on every return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      wcnt        <= '0;
      rem         <= '0;
      tcnt        <= '0;
      key         <= '0;
      nonce       <= '0;
      key_valid   <= 1'b0;
      nonce_valid <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      nonce_valid <= 1'b0;
      if (state == ST_IDLE) begin
        shadow <= '0;
        wcnt   <= '0;
        tcnt   <= '0;
        if (word_valid) rem <= hlen;
      end else if (tmo) begin
        tcnt <= '0;
      end else if (word_valid) begin
        tcnt   <= '0;
        shadow <= {shadow[95:0], word_in};
        wcnt   <= wcnt + 2'd1;
        rem    <= rem - 16'd1;
        if (state == ST_KEY && wcnt == 2'd3) begin
          key       <= {shadow[95:0], word_in};
          key_valid <= 1'b1;
        end
        if (state == ST_NONCE && wcnt == 2'd3) begin
          nonce       <= {shadow[95:0], word_in};
          nonce_valid <= 1'b1;
        end
      end else begin
        tcnt <= tcnt + 32'd1;
      end
    end
  end

  assign buf_in_valid = word_valid && (state == ST_DATA);

  spi_word_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (word_in),
    .in_last   (rem == 16'd1),
    .in_valid  (buf_in_valid),
    .force_last(tmo && (state == ST_DATA)),
    .out_data  (data_out),
    .out_valid (data_valid),
    .out_last  (data_last),
    .out_ready (data_ready),
    .ovf       (ovf)
  );

  always_comb begin
    new_err  = hdr_err || ovf || tmo;
    new_code = ERR_TMO;
    if (hdr_err)  new_code = ERR_HDR;
    else if (ovf) new_code = ERR_OVF;
  end

  // First error wins; a clear in the same cycle beats a new error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      code_q <= ERR_NONE;
    end else if (err_clr) begin
      err    <= 1'b0;
      code_q <= ERR_NONE;
    end else if (new_err && !err) begin
      err    <= 1'b1;
      code_q <= new_code;
    end
  end

  assign err_code = code_q;
  assign busy     = (state != ST_IDLE) || data_valid;

endmodule

// File: tb/tb_ascon_spi_ctrl.sv
// Directed self-checking bench for ascon_spi_ctrl (MAX_LEN=8, TIMEOUT=16).
module tb_ascon_spi_ctrl;

  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  word_in = '0;
  logic         word_valid = 1'b0;
  logic [127:0] key;
  logic         key_valid;
  logic [127:0] nonce;
  logic         nonce_valid;
  logic [31:0]  data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         data_last;
  logic         busy;
  logic         err;
  logic [1:0]   err_code;
  logic         err_clr = 1'b0;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  localparam logic [127:0] KEY1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] NONCE1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] KEY2   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  always #5 clk = ~clk;

  ascon_spi_ctrl #(.MAX_LEN(8), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .key        (key),
    .key_valid  (key_valid),
    .nonce      (nonce),
    .nonce_valid(nonce_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
    .busy       (busy),
    .err        (err),
    .err_code   (err_code),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic send128(input logic [127:0] v);
    logic [127:0] t;
    t = v;
    for (int unsigned i = 0; i < 4; i++) begin
      send(t[127:96]);
      t = t << 32;
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_key", key, '0);
    check("rst_dv", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", {err, err_code}, 3'b000);
    rst = 1'b0;
    tick();

    // LOAD_KEY
    send(32'h1000_0000);
    check("key_busy_hdr", busy, 1'b1);
    send(32'h00112233);
    send(32'h44556677);
    send(32'h8899AABB);
    check("key_not_yet", {key_valid, key}, {1'b0, 128'h0});
    send(32'hCCDDEEFF);
    check("key_val", key, KEY1);
    check("key_valid_pulse", key_valid, 1'b1);
    check("key_busy_done", busy, 1'b0);
    tick();
    check("key_valid_once", key_valid, 1'b0);

    // DATA len 3, ready held high
    data_ready = 1'b1;
    send(32'h3000_0003);
    send(32'hAAAA_0001);
    check("d3_a", {data_valid, data_last, data_out}, {2'b10, 32'hAAAA_0001});
    send(32'hBBBB_0002);
    check("d3_b", {data_valid, data_last, data_out}, {2'b10, 32'hBBBB_0002});
    send(32'hCCCC_0003);
    check("d3_c", {data_valid, data_last, data_out}, {2'b11, 32'hCCCC_0003});
    check("d3_busy_c", busy, 1'b1);
    tick();
    check("d3_drained", {data_valid, data_last, busy}, 3'b000);
    check("d3_noerr", err, 1'b0);

    // DATA len 2, ready low: second word overflows
    data_ready = 1'b0;
    send(32'h3000_0002);
    send(32'h1111_1111);
    send(32'h2222_2222);
    check("ovf_held", {data_valid, data_out}, {1'b1, 32'h1111_1111});
    check("ovf_err", {err, err_code}, 3'b110);
    check("ovf_busy_buf", busy, 1'b1);
    data_ready = 1'b1;
    tick();
    check("ovf_idle", {busy, data_valid}, 2'b00);
    check("ovf_sticky", {err, err_code}, 3'b110);
    clear_err();
    check("ovf_clr", {err, err_code}, 3'b000);

    // Bad headers: first error retained
    send(32'h7000_0000);
    check("hdr_bad_op", {err, err_code, busy}, 4'b1010);
    send(32'h3000_0000);
    check("hdr_len0", {err, err_code, busy}, 4'b1010);
    clear_err();
    check("hdr_clr", {err, err_code}, 3'b000);
    send(32'h3000_0009);
    check("hdr_len_over", {err, err_code, busy}, 4'b1010);
    clear_err();
    err_clr = 1'b1;
    send(32'hF000_0000);
    err_clr = 1'b0;
    check("clr_beats_err", {err, err_code}, 3'b000);

    // Good nonce, then an aborted nonce frame
    send(32'h2000_0000);
    send128(NONCE1);
    check("nonce_val", {nonce_valid, nonce}, {1'b1, NONCE1});
    send(32'h2000_0000);
    send(32'hDEAD_0001);
    send(32'hDEAD_0002);
    for (int unsigned i = 0; i < TMO - 1; i++) begin
      tick();
      check("tmo_no_nv", nonce_valid, 1'b0);
    end
    check("tmo_before", {busy, err}, 2'b10);
    tick();
    check("tmo_hit", {busy, err, err_code}, 4'b0111);
    check("tmo_nonce_kept", {nonce_valid, nonce}, {1'b0, NONCE1});
    clear_err();

    // Timeout with a buffered DATA word: last forced on it
    data_ready = 1'b0;
    send(32'h3000_0003);
    send(32'h5555_AAAA);
    check("tb_last_before", data_last, 1'b0);
    for (int unsigned i = 0; i < TMO; i++) tick();
    check("tb_forced_last", {data_valid, data_last, data_out, err_code}, {2'b11, 32'h5555_AAAA, 2'd3});
    data_ready = 1'b1;
    tick();
    check("tb_drain", {data_valid, busy}, 2'b00);
    clear_err();

    // Reset in the middle of a DATA frame
    data_ready = 1'b0;
    send(32'h3000_0002);
    send(32'h7777_8888);
    check("mid_dv", data_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {data_valid, busy, err, data_out, key, nonce}, '0);
    tick();
    rst = 1'b0;
    tick();
    send(32'h1000_0000);
    send128(KEY2);
    check("post_rst_key", {key_valid, key}, {1'b1, KEY2});
    check("post_rst_dv", data_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
